// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared sizing helpers for the pipelined integer square root.
//   sqrt_rw   - root width for a given radicand width
//   sqrt_nstg - number of registered stages for a given iterations-per-stage
// The per-stage state struct depends on module parameters, so it is declared
// inside sqrt_stage from localparams derived with these helpers.
package sqrt_pkg;

    function automatic int sqrt_rw(input int data_w);
        return data_w / 2;
    endfunction

    function automatic int sqrt_nstg(input int data_w, input int ips);
        return (data_w / 2) / ips;
    endfunction

endpackage

// File: rtl/sqrt_stage.sv
// sqrt_stage: one pipeline stage of the restoring square-root recurrence.
// Performs ITER_PER_STAGE iterations combinationally on the incoming
// {R, Q, X} and registers the result together with valid and tag.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/r/q/x/tag   state from the previous stage (or the input mapping)
//   nxt_ready            load enable of the following stage (o_ready for last)
//   load                 this stage loads this cycle (ready toward upstream)
//   out_valid/r/q/x/tag  registered state
module sqrt_stage
    import sqrt_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ITER_PER_STAGE = 1,
    parameter int TAG_W          = 4,
    localparam int RW            = sqrt_rw(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [RW+1:0]     in_r,
    input  logic [RW-1:0]     in_q,
    input  logic [DATA_W-1:0] in_x,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              nxt_ready,
    output logic              load,
    output logic              out_valid,
    output logic [RW+1:0]     out_r,
    output logic [RW-1:0]     out_q,
    output logic [DATA_W-1:0] out_x,
    output logic [TAG_W-1:0]  out_tag
);

    typedef struct packed {
        logic              valid;
        logic [RW+1:0]     r;
        logic [RW-1:0]     q;
        logic [DATA_W-1:0] x;
        logic [TAG_W-1:0]  tag;
    } stage_t;

    stage_t stage_d, stage_q;

    logic [RW+1:0]     r_it;
    logic [RW-1:0]     q_it;
    logic [DATA_W-1:0] x_it;
    logic [RW+3:0]     trial;
    logic [RW+1:0]     diff;

    // The remainder never exceeds 2*Q, so the subtraction result and the
    // restored value both fit in RW+2 bits; only the compare needs RW+4.
    always_comb begin
        r_it  = in_r;
        q_it  = in_q;
        x_it  = in_x;
        trial = '0;
        diff  = '0;
        for (int i = 0; i < ITER_PER_STAGE; i++) begin
            trial = {r_it, x_it[DATA_W-1 -: 2]};
            if (trial >= {2'b00, q_it, 2'b01}) begin
                diff = trial[RW+1:0] - {q_it, 2'b01};
                r_it = diff;
                q_it = {q_it[RW-2:0], 1'b1};
            end else begin
                r_it = trial[RW+1:0];
                q_it = {q_it[RW-2:0], 1'b0};
            end
            x_it = {x_it[DATA_W-3:0], 2'b00};
        end
    end

    // An empty register always loads, so bubbles collapse.
    assign load = !stage_q.valid || nxt_ready;

    always_comb begin
        stage_d = stage_q;
        if (load) begin
            stage_d = '{valid: in_valid, r: r_it, q: q_it, x: x_it, tag: in_tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_valid = stage_q.valid;
    assign out_r     = stage_q.r;
    assign out_q     = stage_q.q;
    assign out_x     = stage_q.x;
    assign out_tag   = stage_q.tag;

endmodule

// File: rtl/sqrt_pipe.sv
// sqrt_pipe: fully pipelined unsigned integer square root with valid/ready.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_valid/i_ready   input handshake; data_i radicand, tag_i sideband
//   o_valid/o_ready   output handshake
//   data_o            floor root (ROUND=0) or nearest root (ROUND=1)
//   data_r            floor remainder data_i - floor_root^2
//   tag_o             tag carried with the result
//   o_sat             rounding would overflow the root width (ROUND=1 only)
// Result comes straight from the last stage register; outputs are forced to 0
// while o_valid is low.
module sqrt_pipe
    import sqrt_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ITER_PER_STAGE = 1,
    parameter int ROUND          = 0,
    parameter int TAG_W          = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [TAG_W-1:0]    tag_i,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [DATA_W/2-1:0] data_o,
    output logic [DATA_W/2:0]   data_r,
    output logic [TAG_W-1:0]    tag_o,
    output logic                o_sat
);

    localparam int RW   = sqrt_rw(DATA_W);
    localparam int NSTG = sqrt_nstg(DATA_W, ITER_PER_STAGE);

    if ((DATA_W % 2) != 0 || DATA_W < 4) begin : g_bad_width
        $error("sqrt_pipe: DATA_W must be even and at least 4");
    end
    if ((RW % ITER_PER_STAGE) != 0) begin : g_bad_ips
        $error("sqrt_pipe: ITER_PER_STAGE must divide DATA_W/2");
    end

    // Index k is the state entering stage k; index NSTG is the final result.
    logic              v_a   [0:NSTG];
    logic [RW+1:0]     r_a   [0:NSTG];
    logic [RW-1:0]     q_a   [0:NSTG];
    logic [DATA_W-1:0] x_a   [0:NSTG];
    logic [TAG_W-1:0]  t_a   [0:NSTG];
    logic              rdy_a [0:NSTG];

    assign v_a[0]      = i_valid;
    assign r_a[0]      = '0;
    assign q_a[0]      = '0;
    assign x_a[0]      = data_i;
    assign t_a[0]      = tag_i;
    assign rdy_a[NSTG] = o_ready;
    assign i_ready     = rdy_a[0];

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        sqrt_stage #(
            .DATA_W         (DATA_W),
            .ITER_PER_STAGE (ITER_PER_STAGE),
            .TAG_W          (TAG_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (v_a[k]),
            .in_r      (r_a[k]),
            .in_q      (q_a[k]),
            .in_x      (x_a[k]),
            .in_tag    (t_a[k]),
            .nxt_ready (rdy_a[k+1]),
            .load      (rdy_a[k]),
            .out_valid (v_a[k+1]),
            .out_r     (r_a[k+1]),
            .out_q     (q_a[k+1]),
            .out_x     (x_a[k+1]),
            .out_tag   (t_a[k+1])
        );
    end

    logic          round_up;
    logic          sat;
    logic [RW-1:0] root;

    // sqrt(N) >= Q + 1/2 reduces to R > Q for integer N = Q^2 + R.
    always_comb begin
        round_up = (ROUND != 0) && (r_a[NSTG] > {2'b00, q_a[NSTG]});
        sat      = round_up && (&q_a[NSTG]);
        root     = q_a[NSTG];
        if (round_up && !sat) begin
            root = q_a[NSTG] + RW'(1);
        end
    end

    assign o_valid = v_a[NSTG];
    assign data_o  = o_valid ? root : '0;
    assign data_r  = o_valid ? r_a[NSTG][RW:0] : '0;
    assign tag_o   = o_valid ? t_a[NSTG] : '0;
    assign o_sat   = o_valid && sat;

endmodule

// File: tb/tb_sqrt_pipe.sv
module tb_sqrt_pipe;

    localparam int NSTG_M = 8;
    localparam int NSTG_W = 4;

    logic clk;
    logic rst_n;

    // main instance: DATA_W=16, IPS=1, ROUND=0
    logic        i_valid, i_ready, o_valid, o_ready, o_sat;
    logic [15:0] data_i;
    logic [3:0]  tag_i, tag_o;
    logic [7:0]  data_o;
    logic [8:0]  data_r;

    // rounding instance: DATA_W=16, IPS=1, ROUND=1
    logic        r_i_valid, r_i_ready, r_o_valid, r_o_sat;
    logic [15:0] r_data_i;
    logic [3:0]  r_tag_i, r_tag_o;
    logic [7:0]  r_data_o;
    logic [8:0]  r_data_r;

    // wide instance: DATA_W=24, IPS=3, ROUND=0
    logic        w_i_valid, w_i_ready, w_o_valid, w_o_sat;
    logic [23:0] w_data_i;
    logic [3:0]  w_tag_i, w_tag_o;
    logic [11:0] w_data_o;
    logic [12:0] w_data_r;

    sqrt_pipe #(.DATA_W(16), .ITER_PER_STAGE(1), .ROUND(0), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
        .data_i(data_i), .tag_i(tag_i), .o_valid(o_valid), .o_ready(o_ready),
        .data_o(data_o), .data_r(data_r), .tag_o(tag_o), .o_sat(o_sat)
    );

    sqrt_pipe #(.DATA_W(16), .ITER_PER_STAGE(1), .ROUND(1), .TAG_W(4)) dut_r (
        .clk(clk), .rst_n(rst_n), .i_valid(r_i_valid), .i_ready(r_i_ready),
        .data_i(r_data_i), .tag_i(r_tag_i), .o_valid(r_o_valid), .o_ready(1'b1),
        .data_o(r_data_o), .data_r(r_data_r), .tag_o(r_tag_o), .o_sat(r_o_sat)
    );

    sqrt_pipe #(.DATA_W(24), .ITER_PER_STAGE(3), .ROUND(0), .TAG_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .i_valid(w_i_valid), .i_ready(w_i_ready),
        .data_i(w_data_i), .tag_i(w_tag_i), .o_valid(w_o_valid), .o_ready(1'b1),
        .data_o(w_data_o), .data_r(w_data_r), .tag_o(w_tag_o), .o_sat(w_o_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        longint d;
        int     t;
        int     c;
        bit     lat;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          lat_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [7:0]  snap_o;
    logic [8:0]  snap_r;
    logic [3:0]  snap_t;

    function automatic longint isqrt(input longint n);
        longint r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle on the main instance: drive at the falling edge, then check
    // the output side against the scoreboard and record an input accept.
    task automatic step(input logic iv, input logic [15:0] d, input logic [3:0] t,
                        input logic ordy, output logic acc);
        exp_t e;
        longint fr;
        @(negedge clk);
        i_valid = iv; data_i = d; tag_i = t; o_ready = ordy;
        #1;
        cyc++;
        if (stall_prev) begin
            chk("stall_valid", o_valid, 1);
            chk("stall_data", data_o, snap_o);
            chk("stall_rem", data_r, snap_r);
            chk("stall_tag", tag_o, snap_t);
        end
        if (o_valid) begin
            chk("out_expected", sbq.size() > 0, 1);
            if (o_ready && sbq.size() > 0) begin
                e = sbq.pop_front();
                fr = isqrt(e.d);
                chk("root", data_o, 32'(fr));
                chk("rem", data_r, 32'(e.d - fr * fr));
                chk("tag", tag_o, e.t);
                if (e.lat) chk("latency", cyc - e.c, NSTG_M);
            end
        end else begin
            chk("idle_zero", {data_o, data_r, tag_o}, 0);
        end
        chk("o_sat_floor", o_sat, 0);
        stall_prev = o_valid && !o_ready;
        snap_o = data_o; snap_r = data_r; snap_t = tag_o;
        acc = i_valid && i_ready;
        if (acc) sbq.push_back('{d: longint'(d), t: int'(t), c: cyc, lat: lat_en});
    endtask

    task automatic drain();
        int g = 0;
        logic a;
        while (sbq.size() > 0 && g < 60) begin
            step(1'b0, 16'd0, 4'd0, 1'b1, a);
            g++;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    task automatic run_r(input logic [15:0] n);
        longint fr, rr, er;
        logic es;
        int k;
        fr = isqrt(longint'(n));
        rr = longint'(n) - fr * fr;
        er = (((fr + 1) * (fr + 1) - longint'(n)) < rr) ? fr + 1 : fr;
        es = 1'b0;
        if (er > 255) begin er = 255; es = 1'b1; end
        @(negedge clk);
        r_data_i = n; r_tag_i = n[3:0]; r_i_valid = 1'b1;
        #1 chk("r_i_ready", r_i_ready, 1);
        @(negedge clk);
        r_i_valid = 1'b0;
        k = 1;
        while (!r_o_valid && k < 20) begin @(negedge clk); k++; end
        chk("r_latency", k, NSTG_M);
        chk("r_root", r_data_o, 32'(er));
        chk("r_sat", r_o_sat, es);
        chk("r_rem", r_data_r, 32'(rr));
        chk("r_tag", r_tag_o, n[3:0]);
    endtask

    task automatic run_w(input logic [23:0] n);
        longint fr;
        int k;
        fr = isqrt(longint'(n));
        @(negedge clk);
        w_data_i = n; w_tag_i = n[7:4]; w_i_valid = 1'b1;
        #1 chk("w_i_ready", w_i_ready, 1);
        @(negedge clk);
        w_i_valid = 1'b0;
        k = 1;
        while (!w_o_valid && k < 20) begin @(negedge clk); k++; end
        chk("w_latency", k, NSTG_W);
        chk("w_root", w_data_o, 32'(fr));
        chk("w_rem", w_data_r, 32'(longint'(n) - fr * fr));
        chk("w_tag", w_tag_o, n[7:4]);
        chk("w_sat", w_o_sat, 0);
    endtask

    initial begin
        logic a;
        int   k;
        int   g;
        logic [15:0] cd;
        logic [3:0]  ct;

        rst_n = 1'b0;
        i_valid = 1'b0; data_i = '0; tag_i = '0; o_ready = 1'b1;
        r_i_valid = 1'b0; r_data_i = '0; r_tag_i = '0;
        w_i_valid = 1'b0; w_data_i = '0; w_tag_i = '0;

        // reset state
        @(negedge clk);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_outs", {data_o, data_r, tag_o, o_sat}, 0);
        chk("rst_r_outs", {r_o_valid, r_data_o, r_data_r, r_o_sat}, 0);
        chk("rst_w_outs", {w_o_valid, w_data_o, w_data_r}, 0);
        rst_n = 1'b1;
        #1 chk("rst_i_ready", i_ready, 1);

        // back-to-back directed words with latency check
        lat_en = 1'b1;
        step(1'b1, 16'd65535, 4'd1, 1'b1, a);
        step(1'b1, 16'd0,     4'd2, 1'b1, a);
        step(1'b1, 16'd50,    4'd3, 1'b1, a);
        step(1'b1, 16'd1,     4'd4, 1'b1, a);
        drain();

        // backpressure: 0..31 with random o_ready
        lat_en = 1'b0;
        k = 0; g = 0;
        while ((k < 32 || sbq.size() > 0) && g < 600) begin
            step(k < 32, 16'(k), 4'(k), $urandom_range(0, 99) < 55, a);
            if (a) k++;
            g++;
        end
        chk("bp_sent", k, 32);
        chk("bp_empty", sbq.size(), 0);

        // randomized sweep with random valid/ready
        k = 0; g = 0;
        cd = 16'($urandom_range(0, 65535)); ct = 4'($urandom_range(0, 15));
        while ((k < 60 || sbq.size() > 0) && g < 1000) begin
            step((k < 60) && ($urandom_range(0, 3) != 0), cd, ct,
                 $urandom_range(0, 99) < 70, a);
            if (a) begin
                k++;
                cd = 16'($urandom_range(0, 65535));
                ct = 4'($urandom_range(0, 15));
            end
            g++;
        end
        chk("rand_sent", k, 60);
        chk("rand_empty", sbq.size(), 0);

        // fill pipe while stalled, then accept and drain in the same cycle
        k = 0;
        repeat (10) begin
            step(1'b1, 16'(200 + k), 4'(k), 1'b0, a);
            if (a) k++;
        end
        chk("fill_count", k, NSTG_M);
        chk("full_i_ready", i_ready, 0);
        repeat (3) begin
            step(1'b1, 16'(200 + k), 4'(k), 1'b1, a);
            chk("sim_i_ready", i_ready, 1);
            chk("sim_accept", a, 1);
            if (a) k++;
        end
        drain();

        // asynchronous reset with words in flight
        for (int i = 0; i < 5; i++) step(1'b1, 16'(1000 + i * 37), 4'(i), 1'b0, a);
        repeat (4) step(1'b0, 16'd0, 4'd0, 1'b0, a);
        chk("pre_rst_valid", o_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_o_valid", o_valid, 0);
        chk("async_data_o", data_o, 0);
        chk("async_data_r", data_r, 0);
        sbq.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_i_ready", i_ready, 1);
        lat_en = 1'b1;
        step(1'b1, 16'd144, 4'd5, 1'b1, a);
        drain();
        repeat (4) step(1'b0, 16'd0, 4'd0, 1'b1, a);

        // rounding instance
        run_r(16'd56);
        run_r(16'd57);
        run_r(16'd65535);
        run_r(16'd0);
        repeat (6) run_r(16'($urandom_range(0, 65535)));

        // wide instance
        run_w(24'd16777215);
        run_w(24'd0);
        repeat (10) run_w(24'($urandom_range(0, 16777215)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
